// File: rtl/junction_if.sv
// Signal bundle between the junction arbiter and the track-side equipment:
// train sensors and operator acknowledge in, point/aspect drives and status out.
interface junction_if;
   logic       sensor1;
   logic       sensor2;
   logic       exit_sensor;
   logic       fault_clr;
   logic       switch1;
   logic       switch2;
   logic       signal1;
   logic       signal2;
   logic       busy;
   logic       fault;
   logic [1:0] state_dbg;

   // Level-sensitive, no handshake: sensors are sampled every rising clk edge and
   // every output holds its registered value for the whole following cycle.
   modport master (
      output sensor1, sensor2, exit_sensor, fault_clr,
      input  switch1, switch2, signal1, signal2, busy, fault, state_dbg
   );

   modport slave (
      input  sensor1, sensor2, exit_sensor, fault_clr,
      output switch1, switch2, signal1, signal2, busy, fault, state_dbg
   );
endinterface

// File: rtl/junction_arbiter.sv
// Two-track railway junction arbiter: round-robin allocation, point settling
// delay before the proceed aspect, and an occupancy timeout that latches a fault.
module junction_arbiter #(
   parameter int unsigned SETTLE  = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input logic       clk,
   input logic       rest,
   junction_if.slave jif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_GRANT  = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   // owner / last_served: 0 = track 1, 1 = track 2
   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [15:0] cnt_q, cnt_d;
   logic        switch1_q, switch1_d, switch2_q, switch2_d;
   logic        signal1_q, signal1_d, signal2_q, signal2_d;
   logic        busy_q, busy_d, fault_q, fault_d;
   logic        owner_req;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      owner_req = owner_q ? jif.sensor2 : jif.sensor1;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (jif.sensor1 && jif.sensor2) begin
               owner_d = ~last_q;
               state_d = S_SETTLE;
            end else if (jif.sensor1) begin
               owner_d = 1'b0;
               state_d = S_SETTLE;
            end else if (jif.sensor2) begin
               owner_d = 1'b1;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // A withdrawn request abandons the allocation before the aspect clears.
            if (!owner_req) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = S_GRANT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_GRANT: begin
            if (jif.exit_sensor) begin
               state_d = S_IDLE;
               last_d  = owner_q;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_FAULT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_FAULT: begin
            cnt_d = '0;
            if (jif.fault_clr) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so they change on the deciding edge.
      switch1_d = ((state_d == S_SETTLE) || (state_d == S_GRANT)) && !owner_d;
      switch2_d = ((state_d == S_SETTLE) || (state_d == S_GRANT)) &&  owner_d;
      signal1_d = (state_d == S_GRANT) && !owner_d;
      signal2_d = (state_d == S_GRANT) &&  owner_d;
      busy_d    = (state_d != S_IDLE);
      fault_d   = (state_d == S_FAULT);
   end

   always_ff @(posedge clk) begin
      if (!rest) begin
         state_q   <= S_IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         switch1_q <= 1'b0;
         switch2_q <= 1'b0;
         signal1_q <= 1'b0;
         signal2_q <= 1'b0;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         switch1_q <= switch1_d;
         switch2_q <= switch2_d;
         signal1_q <= signal1_d;
         signal2_q <= signal2_d;
         busy_q    <= busy_d;
         fault_q   <= fault_d;
      end
   end

   assign jif.switch1   = switch1_q;
   assign jif.switch2   = switch2_q;
   assign jif.signal1   = signal1_q;
   assign jif.signal2   = signal2_q;
   assign jif.busy      = busy_q;
   assign jif.fault     = fault_q;
   assign jif.state_dbg = state_q;

endmodule

// File: tb/tb_junction_arbiter.sv
// Directed bench for junction_arbiter (SETTLE=4, TIMEOUT=16): a vector table,
// hand-written multi-cycle sequences, and a random run under a mutual-exclusion monitor.
module tb_junction_arbiter;

   logic clk;
   logic rest;
   int   checks;
   int   passed;
   int   viol;
   logic mon_en;

   junction_if jif ();

   junction_arbiter #(.SETTLE(4), .TIMEOUT(16)) dut (
      .clk  (clk),
      .rest (rest),
      .jif  (jif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output patterns, packed as {switch1, switch2, signal1, signal2, busy, fault}
   localparam logic [5:0] IDLE0 = 6'b000000;
   localparam logic [5:0] ST1   = 6'b100010;
   localparam logic [5:0] GR1   = 6'b101010;
   localparam logic [5:0] ST2   = 6'b010010;
   localparam logic [5:0] GR2   = 6'b010110;
   localparam logic [5:0] FLT   = 6'b000011;

   typedef struct {
      logic       r;
      logic       s1;
      logic       s2;
      logic       ex;
      logic       clr;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs [19];

   task automatic set_in(input logic r, input logic s1, input logic s2,
                         input logic ex, input logic clr);
      rest            = r;
      jif.sensor1     = s1;
      jif.sensor2     = s2;
      jif.exit_sensor = ex;
      jif.fault_clr   = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string name, input logic [5:0] exp);
      logic [5:0] got;
      got = {jif.switch1, jif.switch2, jif.signal1, jif.signal2, jif.busy, jif.fault};
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %b expected %b (sw1 sw2 sig1 sig2 busy fault)", name, got, exp);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if ((jif.switch1 && jif.switch2) || (jif.signal1 && jif.signal2) ||
             (jif.signal1 && !jif.switch1) || (jif.signal2 && !jif.switch2) ||
             (jif.fault && (jif.switch1 || jif.switch2)))
            viol++;
      end
   end

   initial begin
      checks = 0;
      passed = 0;
      viol   = 0;
      mon_en = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      //                r     s1    s2    ex    clr   expected
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ST1};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ST1};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ST1};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ST1};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GR1};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, GR1};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, IDLE0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ST2};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ST2};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ST2};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ST2};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, GR2};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, IDLE0};
      vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ST1};
      vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE0};
      vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ST1};
      vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, IDLE0};

      for (int i = 0; i < 19; i++) begin
         set_in(vecs[i].r, vecs[i].s1, vecs[i].s2, vecs[i].ex, vecs[i].clr);
         tick();
         check($sformatf("vec%0d", i), vecs[i].exp);
         if (i == 0) begin
            mon_en = 1'b1;
            checks++;
            if (jif.state_dbg === 2'd0) passed++;
            else $display("FAIL reset_state: got %0d expected 0", jif.state_dbg);
         end
      end

      // Tie held from reset: track 1, then track 2, then track 1 again.
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick(); check("alt_reset", IDLE0);
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick(); check("alt_settle1", ST1);
      ticks(3); tick(); check("alt_grant1", GR1);
      jif.exit_sensor = 1'b1; tick(); check("alt_exit1", IDLE0);
      jif.exit_sensor = 1'b0; tick(); check("alt_settle2", ST2);
      ticks(3); tick(); check("alt_grant2", GR2);
      jif.exit_sensor = 1'b1; tick(); check("alt_exit2", IDLE0);
      jif.exit_sensor = 1'b0; tick(); check("alt_settle1b", ST1);

      // Track-2 request withdrawn mid-settle; round-robin pointer must not move.
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick(); check("abort_settle", ST2);
      ticks(2); check("abort_hold", ST2);
      jif.sensor2 = 1'b0; tick(); check("abort_drop", IDLE0);
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick(); check("abort_tie", ST1);

      // Occupancy timeout, fault latch, and operator clear.
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      ticks(3); tick(); check("to_grant", GR1);
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); ticks(15); check("to_hold15", GR1);
      tick(); check("to_fault", FLT);
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); ticks(3); check("fault_ignore", FLT);
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); tick(); check("fault_clr", IDLE0);
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick(); check("fault_tie", ST1);
      ticks(3); tick(); check("ew_grant", GR1);
      ticks(15); check("ew_hold15", GR1);
      jif.exit_sensor = 1'b1; tick(); check("exit_wins", IDLE0);

      // Reset in the middle of a grant, then a fresh allocation for track 2.
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      ticks(3); tick(); check("rg_grant", GR1);
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick(); check("rg_reset", IDLE0);
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick(); check("rg_settle2", ST2);
      ticks(3); tick(); check("rg_grant2", GR2);

      // Random traffic; the monitor counts any exclusion violation.
      for (int i = 0; i < 3000; i++) begin
         set_in(($urandom_range(0, 199) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
         tick();
      end
      checks++;
      if (viol == 0) passed++;
      else $display("FAIL mutex: got %0d violations expected 0", viol);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/junction_arbiter.md
JUNCTION_ARBITER -- requirements
Module: junction_arbiter

Interface
REQ-001 Parameter SETTLE, default 8: switch-settling time in clock cycles (range 1 to 65535).
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles a granted train may occupy the junction (range 1 to 65535).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rest  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 sensor1  input  1  track-1 train approaching, requesting the junction.
REQ-006 sensor2  input  1  track-2 train approaching, requesting the junction.
REQ-007 exit_sensor  input  1  granted train has cleared the junction.
REQ-008 fault_clr  input  1  operator acknowledge; leaves FAULT.
REQ-009 switch1  output  1  drive junction points toward track 1.
REQ-010 switch2  output  1  drive junction points toward track 2.
REQ-011 signal1  output  1  track-1 proceed aspect (1 = green).
REQ-012 signal2  output  1  track-2 proceed aspect (1 = green).
REQ-013 busy  output  1  junction allocated or faulted (state != IDLE).
REQ-014 fault  output  1  occupancy timeout latched.

Function
REQ-015 The block SHALL implement states IDLE, SETTLE, GRANT and FAULT, plus a 1-bit owner register, a 1-bit last-served register and a 16-bit cycle counter; all outputs SHALL be registered.
REQ-016 IDLE: all switch and signal outputs 0; sensor1 only -> owner=1, SETTLE; sensor2 only -> owner=2, SETTLE; neither -> stay in IDLE.
REQ-017 IDLE with sensor1 and sensor2 both high SHALL grant the track not recorded in last-served (round-robin); after reset, track 1 wins the first tie.
REQ-018 On entry to SETTLE, the counter SHALL clear and the owner's switch output SHALL rise on the clock edge that samples the request.
REQ-019 SETTLE: counter increments each cycle; when count == SETTLE-1 -> GRANT with counter cleared; the owner's signal SHALL rise exactly SETTLE cycles after its switch.
REQ-020 SETTLE: if the owner's sensor drops to 0, the block SHALL return to IDLE next edge, drop the switch and leave last-served unchanged.
REQ-021 GRANT: the owner's switch and signal SHALL be 1; counter increments; owner-sensor changes SHALL be ignored.
REQ-022 GRANT with exit_sensor=1 -> IDLE; signal and switch drop on the same edge; last-served := owner.
REQ-023 GRANT with count == TIMEOUT-1 and exit_sensor=0 -> FAULT; if exit_sensor=1 on that same cycle, exit SHALL win.
REQ-024 exit_sensor SHALL be ignored in IDLE, SETTLE and FAULT.
REQ-025 FAULT: all switch and signal outputs 0, fault=1, requests ignored; fault_clr=1 -> IDLE next edge with fault=0; last-served unchanged.
REQ-026 Mutual exclusion SHALL hold every cycle: never switch1&switch2, never signal1&signal2, and a signal never without its own switch.
REQ-027 From an IDLE return, a pending request SHALL be accepted no earlier than the next edge (one idle cycle minimum between grants).
REQ-028 The counter SHALL never wrap; it saturates at its terminal value for the current state.

Reset
REQ-029 With rest=0 at a clock edge: state=IDLE, switch1=switch2=signal1=signal2=0, busy=0, fault=0, counter=0, last-served=track 2 (so track 1 wins the first tie).
REQ-030 Reset SHALL override all inputs, including mid-SETTLE, mid-GRANT and FAULT; fault_clr is not needed after reset.

Verification
REQ-031 SETTLE=4: sensor1=1 sampled at edge k -> switch1=1 from k, signal1=1 from k+4; exit_sensor pulse at edge m -> both 0 from m, busy=0.
REQ-032 sensor1=sensor2=1 held after reset -> track 1 served first; after its exit, track 2 served next; then track 1 again (alternation).
REQ-033 sensor2 raised then dropped after 2 cycles of SETTLE (SETTLE=4) -> switch2 falls, signal2 never rises; next tie still goes to track 1.
REQ-034 TIMEOUT=16, granted with no exit -> fault=1 and all outputs 0 exactly 16 cycles after the signal rose; sensors ignored; fault_clr=1 -> IDLE, fault=0.
REQ-035 rest=0 asserted mid-GRANT -> all outputs 0 at that edge; with rest=1 and sensor2=1, the grant restarts from SETTLE.
REQ-036 Random sensor, exit and fault_clr stimulus over 100k cycles -> assertion of REQ-026 never fires.
